stage_d_rv: RTL and testbench
=============================

# stage_d_rv

RISC-V decode stage for the pipelined core, directly downstream of fetch. Captures the fetch PC pair into an IF/ID register, accepts the D-aligned instruction word from the synchronous program ROM, and owns the 32×32 integer register file. It produces register operands, the sign-extended immediate and the main/ALU control word for the execute stage, and honours the StallD/FlushD controls of the hazard unit.

## Interface
No parameters. Reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- RDD  in  32  instruction word from program ROM, already D-aligned
- PCF, PCPlus4F  in  32 each  fetch PC and PC+4
- StallD, FlushD  in  1 each  hazard-unit hold / kill of the D stage
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- PCD, PCPlus4D  out  32 each  registered PC pair
- ValidD  out  1  D holds a real instruction
- InstrD  out  32  instruction in D after kill masking
- Rs1D, Rs2D, RdD  out  5 each  InstrD[19:15], [24:20], [11:7]
- RD1D, RD2D  out  32 each  register operands
- ImmExtD  out  32  sign-extended immediate
- RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD  out  1 each  control
- ResultSrcD  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlD  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- IllegalD  out  1  valid instruction with unsupported encoding

## Operation
- IF/ID register priority: rst > FlushD > StallD > load. rst or FlushD: PCD=0, PCPlus4D=0, ValidD=0. StallD (no flush): hold all. Otherwise load PCF, PCPlus4F, ValidD=1.
- InstrD = RDD when ValidD, else 0x00000013 (addi x0,x0,0).
- Supported: lw, sw, beq, jal, R-type add/sub/and/or/xor/slt/sll/srl, I-type addi/andi/ori/xori/slti/slli/srli. R-type sub selected by funct7[5]; I-type ignores funct7 except slli/srli require funct7=0.
- Unsupported opcode/funct with ValidD=1: IllegalD=1, all control outputs 0. ValidD=0: all control and IllegalD forced 0.
- Controls: lw RegWrite, ALUSrc, ResultSrc=01, add; sw MemWrite, ALUSrc, add; beq Branch, sub; jal RegWrite, Jump, ResultSrc=10; R-type RegWrite; I-ALU RegWrite, ALUSrc.
- Immediate by opcode: I {20×[31],[31:20]}; S {20×[31],[31:25],[11:7]}; B {19×[31],[31],[7],[30:25],[11:8],0}; J {11×[31],[31],[19:12],[20],[30:21],0}; R-type/illegal 0.
- Register file: x0 reads 0, never written. Write at rising edge when RegWriteW and RdW≠0. Read combinational with write-through bypass: if RegWriteW, RdW≠0 and RdW equals read index, return ResultW.
- rst clears all 31 registers to 0.

## Timing
- Reset values: PCD=0, PCPlus4D=0, ValidD=0, InstrD=0x00000013, all controls/IllegalD=0, RD1D=RD2D=0, ImmExtD=0.
- Latency: PCF→PCD one cycle; RDD→decoded outputs combinational same cycle.
- Writeback→read: same-cycle via bypass; no extra stall required.
- FlushD with StallD: flush wins, bubble inserted.
- StallD held N cycles: PCD/ValidD constant N cycles; RDD held by fetch.
- rst mid-stall: registers and IF/ID cleared next edge regardless of StallD.

## Test plan
- Reset, then PCF=0x40/PCPlus4F=0x44, RDD=0x00500093 (addi x1,x0,5) -> next cycle PCD=0x40, ValidD=1, RegWriteD=1, ALUSrcD=1, ImmExtD=5, ALUControlD=000.
- RegWriteW=1, RdW=1, ResultW=0xDEADBEEF with InstrD reading rs1=x1 -> RD1D=0xDEADBEEF same cycle; write RdW=0 -> x0 still reads 0.
- RDD=0xFE000EE3 (beq x0,x0,-4) -> BranchD=1, ALUControlD=001, ImmExtD=0xFFFFFFFC; jal x1,+2048 (0x001000EF) -> ImmExtD=0x00000800, ResultSrcD=10.
- StallD=1 three cycles with changing PCF -> PCD unchanged; FlushD=1 with StallD=1 -> ValidD=0, InstrD=0x00000013, RegWriteD=0.
- RDD=0x0000007F (bad opcode) -> IllegalD=1, all controls 0; same with ValidD=0 -> IllegalD=0.
- rst asserted during stall -> all outputs at reset values next cycle, register reads 0.

Source files
------------

// File: rtl/stage_d_rv.sv
// stage_d_rv: decode stage of the pipelined RISC-V core.
//
// This stage holds the IF/ID register with the fetch PC pair and a valid bit.
// It decodes the D-aligned instruction word, which comes straight from the
// synchronous program ROM, and it owns the 32x32 integer register file.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   RDD                 instruction word from ROM, already aligned to D
//   PCF, PCPlus4F       fetch PC and PC+4
//   StallD, FlushD      hazard-unit hold and kill of the D stage
//   RegWriteW/RdW/ResultW  writeback port into the register file
//   PCD, PCPlus4D, ValidD  IF/ID register contents
//   InstrD              instruction in D; a nop when D holds a bubble
//   Rs1D, Rs2D, RdD     register indices taken from InstrD
//   RD1D, RD2D          register operands, with writeback bypass
//   ImmExtD             sign-extended immediate
//   RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUControlD
//                       control word for the execute stage
//   IllegalD            valid instruction whose encoding is not supported
module stage_d_rv (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] RDD,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ImmExtD,
    output logic        RegWriteD,
    output logic        MemWriteD,
    output logic        BranchD,
    output logic        JumpD,
    output logic        ALUSrcD,
    output logic [1:0]  ResultSrcD,
    output logic [2:0]  ALUControlD,
    output logic        IllegalD
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // funct3 -> ALU operation, shared by R-type and I-type ALU instructions
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub ? 3'b001 : 3'b000;
            3'b111:  op = 3'b010;
            3'b110:  op = 3'b011;
            3'b100:  op = 3'b100;
            3'b010:  op = 3'b101;
            3'b001:  op = 3'b110;
            3'b101:  op = 3'b111;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    // ---- stage p1: IF/ID register ----
    logic [31:0] pc_p1_q, pc_p1_d;
    logic [31:0] pc4_p1_q, pc4_p1_d;
    logic        vld_p1_q, vld_p1_d;

    always_comb begin
        pc_p1_d  = pc_p1_q;
        pc4_p1_d = pc4_p1_q;
        vld_p1_d = vld_p1_q;
        // A flush must beat a stall so that a bubble is inserted.
        if (FlushD) begin
            pc_p1_d  = '0;
            pc4_p1_d = '0;
            vld_p1_d = 1'b0;
        end else if (!StallD) begin
            pc_p1_d  = PCF;
            pc4_p1_d = PCPlus4F;
            vld_p1_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p1_q  <= '0;
            pc4_p1_q <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            pc_p1_q  <= pc_p1_d;
            pc4_p1_q <= pc4_p1_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    assign PCD      = pc_p1_q;
    assign PCPlus4D = pc4_p1_q;
    assign ValidD   = vld_p1_q;
    assign InstrD   = vld_p1_q ? RDD : NOP_INSTR;
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];
    assign RdD      = InstrD[11:7];

    // ---- decode (combinational within D) ----
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm;
    logic        legal, reg_write, mem_write, branch, jump, alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctl;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];
    assign imm_i  = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s  = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b  = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j  = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    always_comb begin
        legal      = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_ctl    = 3'b000;
        imm        = '0;
        case (opcode)
            OP_LOAD: if (funct3 == 3'b010) begin
                legal      = 1'b1;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
                imm        = imm_i;
            end
            OP_STORE: if (funct3 == 3'b010) begin
                legal     = 1'b1;
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm       = imm_s;
            end
            OP_BRANCH: if (funct3 == 3'b000) begin
                legal   = 1'b1;
                branch  = 1'b1;
                alu_ctl = 3'b001;
                imm     = imm_b;
            end
            OP_JAL: begin
                legal      = 1'b1;
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                imm        = imm_j;
            end
            // Only sub may set funct7[5]; sltu (funct3=011) is not supported.
            OP_R: if ((funct7 == 7'b0000000 && funct3 != 3'b011) ||
                      (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
                legal     = 1'b1;
                reg_write = 1'b1;
                alu_ctl   = alu_op(funct3, funct7[5]);
            end
            // funct7 only matters for the shifts, where it must be zero.
            OP_I: if (funct3 != 3'b011 &&
                      ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == 7'b0000000)) begin
                legal     = 1'b1;
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = alu_op(funct3, 1'b0);
                imm       = imm_i;
            end
            default: ;
        endcase
    end

    // A bubble decodes as the nop, but it still must not drive any control.
    assign RegWriteD   = vld_p1_q & reg_write;
    assign MemWriteD   = vld_p1_q & mem_write;
    assign BranchD     = vld_p1_q & branch;
    assign JumpD       = vld_p1_q & jump;
    assign ALUSrcD     = vld_p1_q & alu_src;
    assign ResultSrcD  = vld_p1_q ? result_src : 2'b00;
    assign ALUControlD = vld_p1_q ? alu_ctl : 3'b000;
    assign IllegalD    = vld_p1_q & ~legal;
    assign ImmExtD     = imm;

    // ---- register file ----
    // Entry 0 resets to zero and is never written. Reads of x0 are also
    // forced to zero, so the entry is never observed.
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        wb_en, hit1, hit2;

    assign wb_en = RegWriteW && (RdW != 5'd0);

    always_comb begin
        rf_d = rf_q;
        if (wb_en) rf_d[RdW] = ResultW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // The write-through bypass lets writeback and decode share a cycle
    // without a stall.
    assign hit1 = wb_en && (RdW == Rs1D);
    assign hit2 = wb_en && (RdW == Rs2D);
    assign RD1D = (Rs1D == 5'd0) ? 32'd0 : (hit1 ? ResultW : rf_q[Rs1D]);
    assign RD2D = (Rs2D == 5'd0) ? 32'd0 : (hit2 ? ResultW : rf_q[Rs2D]);

endmodule

// File: tb/tb_stage_d_rv.sv
// Scoreboard bench for stage_d_rv: directed vectors push the expected outputs,
// a negedge monitor pops and compares each cycle an entry is pending.
module tb_stage_d_rv;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RDD, PCF, PCPlus4F, ResultW;
    logic        StallD, FlushD, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] PCD, PCPlus4D, InstrD, RD1D, RD2D, ImmExtD;
    logic        ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, IllegalD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;

    always #5 clk = ~clk;

    stage_d_rv dut (
        .clk(clk), .rst(rst), .RDD(RDD), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .FlushD(FlushD), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .InstrD(InstrD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RD1D(RD1D),
        .RD2D(RD2D), .ImmExtD(ImmExtD), .RegWriteD(RegWriteD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .IllegalD(IllegalD)
    );

    // ctrl = {RegWrite, MemWrite, Branch, Jump, ALUSrc, ResultSrc[1:0], ALUControl[2:0], Illegal}
    localparam logic [10:0] C_NONE = 11'b00000000000;
    localparam logic [10:0] C_ADDI = 11'b10001000000;
    localparam logic [10:0] C_SLLI = 11'b10001001100;
    localparam logic [10:0] C_ADD  = 11'b10000000000;
    localparam logic [10:0] C_SUB  = 11'b10000000010;
    localparam logic [10:0] C_BEQ  = 11'b00100000010;
    localparam logic [10:0] C_JAL  = 11'b10010100000;
    localparam logic [10:0] C_LW   = 11'b10001010000;
    localparam logic [10:0] C_SW   = 11'b01001000000;
    localparam logic [10:0] C_ILL  = 11'b00000000001;

    typedef struct packed {
        int          id;
        logic [31:0] pcd;
        logic [31:0] p4d;
        logic        v;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [10:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec%0d: got %0h expected %0h", nm, id, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] pcf, input logic [31:0] p4f, input logic [31:0] rdd,
                       input logic stall, input logic flush, input logic rw,
                       input logic [4:0] rdw, input logic [31:0] resw, input logic r);
        PCF = pcf; PCPlus4F = p4f; RDD = rdd; StallD = stall; FlushD = flush;
        RegWriteW = rw; RdW = rdw; ResultW = resw; rst = r;
    endtask

    task automatic expv(input int id, input logic [31:0] pcd, input logic [31:0] p4d,
                        input logic v, input logic [31:0] instr, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm, input logic [10:0] ctrl);
        exp_t e;
        e.id = id; e.pcd = pcd; e.p4d = p4d; e.v = v; e.instr = instr;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.ctrl = ctrl;
        sb_q.push_back(e);
    endtask

    // Monitor: compares a pending expectation every cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_pair", e.id, {PCD, PCPlus4D}, {e.pcd, e.p4d});
                chk("valid_instr", e.id, {31'd0, ValidD, InstrD}, {31'd0, e.v, e.instr});
                chk("reg_idx", e.id, {49'd0, Rs1D, Rs2D, RdD},
                    {49'd0, e.instr[19:15], e.instr[24:20], e.instr[11:7]});
                chk("operands", e.id, {RD1D, RD2D}, {e.rd1, e.rd2});
                chk("imm", e.id, {32'd0, ImmExtD}, {32'd0, e.imm});
                chk("ctrl", e.id,
                    {53'd0, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUControlD, IllegalD},
                    {53'd0, e.ctrl});
            end
        end
    end

    initial begin
        drv(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        repeat (3) @(posedge clk);

        // reset state visible while first fetch is presented
        tick(); drv(32'h40, 32'h44, 32'h00500093, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(0, 32'h0, 32'h0, 0, 32'h00000013, 32'h0, 32'h0, 32'h0, C_NONE);
        // addi x1,x0,5 loaded
        tick(); drv(32'h40, 32'h44, 32'h00500093, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(1, 32'h40, 32'h44, 1, 32'h00500093, 32'h0, 32'h0, 32'h5, C_ADDI);
        // addi x2,x1,0 with same-cycle writeback of x1 (bypass)
        tick(); drv(32'h44, 32'h48, 32'h00008113, 0, 0, 1, 5'd1, 32'hDEADBEEF, 0);
        expv(2, 32'h40, 32'h44, 1, 32'h00008113, 32'hDEADBEEF, 32'h0, 32'h0, C_ADDI);
        // add x3,x1,x0: x1 from file, write to x0 must not show on rs2
        tick(); drv(32'h48, 32'h4C, 32'h000081B3, 0, 0, 1, 5'd0, 32'h12345678, 0);
        expv(3, 32'h44, 32'h48, 1, 32'h000081B3, 32'hDEADBEEF, 32'h0, 32'h0, C_ADD);
        // sub x4,x0,x1
        tick(); drv(32'h4C, 32'h50, 32'h40100233, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(4, 32'h48, 32'h4C, 1, 32'h40100233, 32'h0, 32'hDEADBEEF, 32'h0, C_SUB);
        // beq x0,x0,-4
        tick(); drv(32'h50, 32'h54, 32'hFE000EE3, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(5, 32'h4C, 32'h50, 1, 32'hFE000EE3, 32'h0, 32'h0, 32'hFFFFFFFC, C_BEQ);
        // jal x1,+2048
        tick(); drv(32'h54, 32'h58, 32'h001000EF, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(6, 32'h50, 32'h54, 1, 32'h001000EF, 32'h0, 32'hDEADBEEF, 32'h00000800, C_JAL);
        // lw x5,8(x1)
        tick(); drv(32'h58, 32'h5C, 32'h0080A283, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(7, 32'h54, 32'h58, 1, 32'h0080A283, 32'hDEADBEEF, 32'h0, 32'h8, C_LW);
        // sw x1,12(x0)
        tick(); drv(32'h5C, 32'h60, 32'h00102623, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(8, 32'h58, 32'h5C, 1, 32'h00102623, 32'h0, 32'hDEADBEEF, 32'hC, C_SW);
        // addi x6,x0,-1
        tick(); drv(32'h60, 32'h64, 32'hFFF00313, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(9, 32'h5C, 32'h60, 1, 32'hFFF00313, 32'h0, 32'h0, 32'hFFFFFFFF, C_ADDI);
        // stall three cycles with a changing PCF, then flush together with stall
        tick(); drv(32'h100, 32'h104, 32'hFFF00313, 1, 0, 0, 5'd0, 32'h0, 0);
        expv(10, 32'h60, 32'h64, 1, 32'hFFF00313, 32'h0, 32'h0, 32'hFFFFFFFF, C_ADDI);
        tick(); drv(32'h200, 32'h204, 32'hFFF00313, 1, 0, 0, 5'd0, 32'h0, 0);
        expv(11, 32'h60, 32'h64, 1, 32'hFFF00313, 32'h0, 32'h0, 32'hFFFFFFFF, C_ADDI);
        tick(); drv(32'h300, 32'h304, 32'hFFF00313, 1, 0, 0, 5'd0, 32'h0, 0);
        expv(12, 32'h60, 32'h64, 1, 32'hFFF00313, 32'h0, 32'h0, 32'hFFFFFFFF, C_ADDI);
        tick(); drv(32'h400, 32'h404, 32'hFFF00313, 1, 1, 0, 5'd0, 32'h0, 0);
        expv(13, 32'h60, 32'h64, 1, 32'hFFF00313, 32'h0, 32'h0, 32'hFFFFFFFF, C_ADDI);
        // flush wins over stall: bubble
        tick(); drv(32'h500, 32'h504, 32'h0000007F, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(14, 32'h0, 32'h0, 0, 32'h00000013, 32'h0, 32'h0, 32'h0, C_NONE);
        // bad opcode while valid -> illegal
        tick(); drv(32'h600, 32'h604, 32'h0000007F, 0, 1, 0, 5'd0, 32'h0, 0);
        expv(15, 32'h500, 32'h504, 1, 32'h0000007F, 32'h0, 32'h0, 32'h0, C_ILL);
        // same word with ValidD=0 -> nothing flagged
        tick(); drv(32'h700, 32'h704, 32'h0000007F, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(16, 32'h0, 32'h0, 0, 32'h00000013, 32'h0, 32'h0, 32'h0, C_NONE);
        // slli with funct7=0100000 is unsupported
        tick(); drv(32'h800, 32'h804, 32'h40309093, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(17, 32'h700, 32'h704, 1, 32'h40309093, 32'hDEADBEEF, 32'h0, 32'h0, C_ILL);
        // slli x1,x1,3
        tick(); drv(32'h900, 32'h904, 32'h00309093, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(18, 32'h800, 32'h804, 1, 32'h00309093, 32'hDEADBEEF, 32'h0, 32'h3, C_SLLI);
        // rst asserted during a stall
        tick(); drv(32'hA00, 32'hA04, 32'h00309093, 1, 0, 0, 5'd0, 32'h0, 1);
        expv(19, 32'h900, 32'h904, 1, 32'h00309093, 32'hDEADBEEF, 32'h0, 32'h3, C_SLLI);
        tick(); drv(32'hA00, 32'hA04, 32'h000081B3, 1, 0, 0, 5'd0, 32'h0, 0);
        expv(20, 32'h0, 32'h0, 0, 32'h00000013, 32'h0, 32'h0, 32'h0, C_NONE);
        tick(); drv(32'hB00, 32'hB04, 32'h000081B3, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(21, 32'h0, 32'h0, 0, 32'h00000013, 32'h0, 32'h0, 32'h0, C_NONE);
        // x1 must read 0 after reset
        tick(); drv(32'hB00, 32'hB04, 32'h000081B3, 0, 0, 0, 5'd0, 32'h0, 0);
        expv(22, 32'hB00, 32'hB04, 1, 32'h000081B3, 32'h0, 32'h0, 32'h0, C_ADD);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", -1, 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
